proc_itr_ctrl: RTL and testbench

Interrupt controller for the `proc_fx` processor. It captures rising edges on up to NSRC interrupt sources into a pending register and applies a processor-writable enable mask. It drives the core's single `itr` input with one pulse per serviced event and sequences service as issue, ID read (acknowledge), then end-of-interrupt write. It sits beside the core on the I/O bus, decoding `req_in`/`addr_in` and `out_en`/`addr_out`, and supplies read data for the external `io_in` mux.

---
 rtl/proc_itr_ctrl.sv | 175 +++++++++++++++++
 tb/tb_proc_itr_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_itr_ctrl.sv
// proc_itr_ctrl: edge-capturing interrupt controller for proc_fx.
// Runs issue -> ID read (ack) -> EOI write, one itr pulse per event.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   irq_src[NSRC]     level interrupt sources, synchronous to clk
//   io_out, addr_out  processor output data / address
//   out_en            processor output strobe (mask write, EOI)
//   addr_in, req_in   processor input address / strobe (ID read)
//   itr               one-cycle interrupt pulse to the core
//   rd_data           ID word for the external io_in mux
//   rd_sel            high when addr_in selects the ID register
module proc_itr_ctrl #(
    parameter int NUBITS   = 16,
    parameter int NSRC     = 4,
    parameter int NUIOIN   = 2,
    parameter int NUIOOU   = 2,
    parameter int ADDR_ID  = 0,
    parameter int ADDR_MSK = 0,
    parameter int ADDR_EOI = 1,
    localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
    localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   irq_src,
    input  logic [NUBITS-1:0] io_out,
    input  logic [AOW-1:0]    addr_out,
    input  logic              out_en,
    input  logic [AIW-1:0]    addr_in,
    input  logic              req_in,
    output logic              itr,
    output logic [NUBITS-1:0] rd_data,
    output logic              rd_sel
);

    localparam int CW = (NSRC > 1) ? $clog2(NSRC) : 1;

    localparam logic [AIW-1:0] A_ID  = AIW'(ADDR_ID);
    localparam logic [AOW-1:0] A_MSK = AOW'(ADDR_MSK);
    localparam logic [AOW-1:0] A_EOI = AOW'(ADDR_EOI);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WACK  = 2'd2,
        WEOI  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [NSRC-1:0] prev;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] msk;
    logic [CW-1:0]   cur;

    logic [NSRC-1:0] edges;
    logic [NSRC-1:0] elig;
    logic [NSRC-1:0] clr;
    logic [CW-1:0]   win;
    logic            any;
    logic            id_rd;
    logic            msk_wr;
    logic            eoi_wr;

    // Upper data bits are not used by the mask; EOI data is ignored.
    logic unused_io;
    assign unused_io = ^io_out[NUBITS-1:NSRC];

    assign edges  = irq_src & ~prev;
    assign elig   = pend & msk;
    assign any    = |elig;
    assign id_rd  = req_in && (addr_in == A_ID);
    assign msk_wr = out_en && (addr_out == A_MSK);
    assign eoi_wr = out_en && (addr_out == A_EOI);

    // Fixed priority: scan downward so the lowest index wins.
    always_comb begin
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win = CW'(i);
            end
        end
    end

    // Only a real acknowledge retires the pending bit; an edge in
    // the same cycle re-sets it below.
    always_comb begin
        clr = '0;
        if (state == WACK && id_rd) begin
            clr = NSRC'(1) << cur;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (any) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WACK;
            end
            WACK: begin
                if (id_rd) begin
                    state_nxt = WEOI;
                end else if (eoi_wr) begin
                    state_nxt = IDLE;
                end
            end
            WEOI: begin
                if (eoi_wr) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        itr     = 1'b0;
        rd_data = {1'b1, {(NUBITS - 1){1'b0}}};
        rd_sel  = (addr_in == A_ID);
        unique case (state)
            IDLE: begin
                itr = 1'b0;
            end
            ISSUE: begin
                itr = 1'b1;
            end
            WACK, WEOI: begin
                rd_data = NUBITS'(cur);
            end
            default: begin
                itr = 1'b0;
            end
        endcase
    end

    // Datapath: edge history, pending, mask, in-service index
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
            pend <= '0;
            msk  <= '1;
            cur  <= '0;
        end else begin
            prev <= irq_src;
            pend <= (pend & ~clr) | edges;
            if (msk_wr) begin
                msk <= io_out[NSRC-1:0];
            end
            if (state == IDLE && any) begin
                cur <= win;
            end
        end
    end

endmodule

// File: tb/tb_proc_itr_ctrl.sv
// tb_proc_itr_ctrl: scoreboard bench for proc_itr_ctrl.
// Expected IDs are queued at stimulus time and popped on ID reads.
module tb_proc_itr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq_src = '0;
    logic [15:0] io_out = '0;
    logic        addr_out = 1'b0;
    logic        out_en = 1'b0;
    logic        addr_in = 1'b1;
    logic        req_in = 1'b0;
    logic        itr;
    logic [15:0] rd_data;
    logic        rd_sel;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    proc_itr_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .io_out   (io_out),
        .addr_out (addr_out),
        .out_en   (out_en),
        .addr_in  (addr_in),
        .req_in   (req_in),
        .itr      (itr),
        .rd_data  (rd_data),
        .rd_sel   (rd_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_itr(input int lim, output int n);
        n = -1;
        for (int k = 1; k <= lim; k++) begin
            tick();
            if (itr === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_ack(output logic [15:0] d);
        req_in  = 1'b1;
        addr_in = 1'b0;
        #1;
        d = rd_data;
        tick();
        req_in  = 1'b0;
        addr_in = 1'b1;
    endtask

    task automatic do_eoi();
        out_en   = 1'b1;
        addr_out = 1'b1;
        tick();
        out_en   = 1'b0;
    endtask

    task automatic do_msk(input logic [3:0] v);
        out_en   = 1'b1;
        addr_out = 1'b0;
        io_out   = {12'h0, v};
        tick();
        out_en   = 1'b0;
        io_out   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (itr !== 1'b0) begin
            bad++;
            $display("FAIL reset_itr got=%b want=0", itr);
        end
        total++;
        if (rd_data !== 16'h8000) begin
            bad++;
            $display("FAIL reset_rd got=%h want=8000", rd_data);
        end
        total++;
        if (dut.msk !== 4'hF || dut.pend !== 4'h0) begin
            bad++;
            $display("FAIL reset_regs msk=%h pend=%h want F/0",
                     dut.msk, dut.pend);
        end
        total++;
        if (rd_sel !== 1'b0) begin
            bad++;
            $display("FAIL reset_sel got=%b want=0", rd_sel);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        logic [15:0] d, e;
        irq_src = 4'b0100;
        exp_q.push_back(16'h0002);
        wait_itr(8, n);
        total++;
        if (n != 2) begin
            bad++;
            $display("FAIL single_lat got=%0d want=2", n);
        end
        tick();
        total++;
        if (itr !== 1'b0) begin
            bad++;
            $display("FAIL single_width got=%b want=0", itr);
        end
        do_ack(d);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin
            bad++;
            $display("FAIL single_id got=%h want=%h", d, e);
        end
        total++;
        if (dut.pend !== 4'h0) begin
            bad++;
            $display("FAIL single_pend got=%h want=0", dut.pend);
        end
        do_ack(d);
        total++;
        if (d !== 16'h0002 || itr !== 1'b0) begin
            bad++;
            $display("FAIL weoi_reread got=%h itr=%b want=0002/0",
                     d, itr);
        end
        do_eoi();
        wait_itr(6, n);
        total++;
        if (n != -1) begin
            bad++;
            $display("FAIL single_level got=%0d want=-1", n);
        end
        irq_src = 4'b0000;
        tick();
    endtask

    task automatic test_priority();
        int n;
        logic [15:0] d, e;
        irq_src = 4'b1010;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0003);
        for (int j = 0; j < 2; j++) begin
            wait_itr(8, n);
            total++;
            if (n != (j == 0 ? 2 : 1)) begin
                bad++;
                $display("FAIL prio_lat%0d got=%0d", j, n);
            end
            tick();
            do_ack(d);
            e = exp_q.pop_front();
            total++;
            if (d !== e) begin
                bad++;
                $display("FAIL prio_id%0d got=%h want=%h", j, d, e);
            end
            do_eoi();
        end
        irq_src = 4'b0000;
        tick();
    endtask

    task automatic test_mask();
        int n;
        logic [15:0] d, e;
        do_msk(4'b1110);
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        wait_itr(6, n);
        total++;
        if (n != -1) begin
            bad++;
            $display("FAIL mask_block got=%0d want=-1", n);
        end
        total++;
        if (dut.pend !== 4'b0001) begin
            bad++;
            $display("FAIL mask_pend got=%h want=1", dut.pend);
        end
        exp_q.push_back(16'h0000);
        do_msk(4'hF);
        wait_itr(6, n);
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL mask_lat got=%0d want=1", n);
        end
        tick();
        do_ack(d);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin
            bad++;
            $display("FAIL mask_id got=%h want=%h", d, e);
        end
        do_eoi();
    endtask

    task automatic test_spurious_abort();
        int n;
        logic [15:0] d, e;
        addr_in = 1'b0;
        #1;
        total++;
        if (rd_sel !== 1'b1) begin
            bad++;
            $display("FAIL sel_id got=%b want=1", rd_sel);
        end
        do_ack(d);
        total++;
        if (d !== 16'h8000) begin
            bad++;
            $display("FAIL spurious got=%h want=8000", d);
        end
        wait_itr(4, n);
        total++;
        if (n != -1 || dut.pend !== 4'h0) begin
            bad++;
            $display("FAIL spurious_fx n=%0d pend=%h want=-1/0",
                     n, dut.pend);
        end
        irq_src = 4'b0100;
        exp_q.push_back(16'h0002);
        wait_itr(8, n);
        tick();
        do_eoi();
        wait_itr(6, n);
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL abort_reissue got=%0d want=1", n);
        end
        tick();
        do_ack(d);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin
            bad++;
            $display("FAIL abort_id got=%h want=%h", d, e);
        end
        do_eoi();
        irq_src = 4'b0000;
        tick();
    endtask

    task automatic test_set_wins();
        int n;
        logic [15:0] d, e;
        irq_src = 4'b0010;
        exp_q.push_back(16'h0001);
        wait_itr(8, n);
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0010;
        exp_q.push_back(16'h0001);
        do_ack(d);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin
            bad++;
            $display("FAIL setwin_id got=%h want=%h", d, e);
        end
        total++;
        if (dut.pend !== 4'b0010) begin
            bad++;
            $display("FAIL setwin_pend got=%h want=2", dut.pend);
        end
        do_eoi();
        wait_itr(6, n);
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL setwin_lat got=%0d want=1", n);
        end
        tick();
        do_ack(d);
        e = exp_q.pop_front();
        total++;
        if (d !== e) begin
            bad++;
            $display("FAIL setwin_id2 got=%h want=%h", d, e);
        end
        do_eoi();
        irq_src = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        logic [15:0] d, e;
        irq_src = 4'b1001;
        exp_q.push_back(16'h0000);
        wait_itr(8, n);
        tick();
        do_ack(d);
        e = exp_q.pop_front();
        total++;
        if (d !== e || dut.pend !== 4'b1000) begin
            bad++;
            $display("FAIL rmid_pre id=%h pend=%h want=%h/8",
                     d, dut.pend, e);
        end
        do_msk(4'b0101);
        rst = 1'b1;
        irq_src = 4'b0000;
        tick();
        total++;
        if (itr !== 1'b0 || rd_data !== 16'h8000) begin
            bad++;
            $display("FAIL rmid_out itr=%b rd=%h want=0/8000",
                     itr, rd_data);
        end
        total++;
        if (dut.pend !== 4'h0 || dut.msk !== 4'hF) begin
            bad++;
            $display("FAIL rmid_regs pend=%h msk=%h want=0/F",
                     dut.pend, dut.msk);
        end
        tick();
        rst = 1'b0;
        wait_itr(8, n);
        total++;
        if (n != -1) begin
            bad++;
            $display("FAIL rmid_noitr got=%0d want=-1", n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_spurious_abort();
        test_set_wins();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_left got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
